boot_mem_arbiter: RTL and testbench

//  Owns the single main-memory port and sequences boot. While the UART program

---
 rtl/boot_mem_arbiter_pkg.sv | 14 +
 rtl/boot_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_boot_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_mem_arbiter_pkg.sv
// Shared definitions for the boot memory arbiter.
//   state_t        : boot sequencer states, encoding visible on the STATE port
//   MEM_BYTES_DEF  : default main-memory size in bytes
package boot_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RUN    = 2'd2
   } state_t;

   localparam int MEM_BYTES_DEF = 512 * 1024;

endpackage

// File: rtl/boot_mem_arbiter.sv
// Boot memory arbiter: owns the single main-memory port.
//   LOAD   : forwards UART loader word writes to memory, CPU held in reset,
//            keeps a checksum and word count of the image.
//   SETTLE : RST_HOLD cycles of delay after LD_DONE, CPU still in reset.
//   RUN    : CPU owns the port, one access per cycle, reads return 2 cycles
//            after grant. Terminal until RST.
// Ports:
//   CLK, RST (sync, active-high)
//   LD_*   : loader write stream and done level
//   CPU_*  : CPU request/grant/read-return interface, CPU_RST out
//   MEM_*  : registered memory strobe/enables/address/data, MEM_RDATA in
//   STATE, CSUM, WCOUNT, ERR : status for the host
module boot_mem_arbiter
   import boot_mem_arbiter_pkg::*;
#(
   parameter int MEM_BYTES = MEM_BYTES_DEF,
   parameter int RST_HOLD  = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] LD_ADDR,
   input  logic [31:0] LD_DATA,
   input  logic        LD_WE,
   input  logic        LD_DONE,
   output logic        CPU_RST,
   input  logic        CPU_REQ,
   input  logic        CPU_WE,
   input  logic [3:0]  CPU_BE,
   input  logic [31:0] CPU_ADDR,
   input  logic [31:0] CPU_WDATA,
   output logic        CPU_GNT,
   output logic [31:0] CPU_RDATA,
   output logic        CPU_RVALID,
   output logic        MEM_EN,
   output logic [3:0]  MEM_WE,
   output logic [31:0] MEM_ADDR,
   output logic [31:0] MEM_WDATA,
   input  logic [31:0] MEM_RDATA,
   output logic [1:0]  STATE,
   output logic [31:0] CSUM,
   output logic [31:0] WCOUNT,
   output logic        ERR
);

   localparam logic [31:0] MEM_LIM     = 32'(MEM_BYTES);
   localparam logic [31:0] SETTLE_LAST = 32'(RST_HOLD - 1);

   state_t      state, state_nx;
   logic [31:0] settle_cnt;

   logic        ld_in_range, cpu_in_range;
   logic        ld_acc, ld_bad, rd_issue;

   // Read-return pipe: stage 1 = request registered, stage 2 = memory data back.
   logic [2:1]  vld_pipe;
   logic [2:1]  oor_pipe;
   logic [31:0] rdata_q;

   assign ld_in_range  = LD_ADDR < MEM_LIM;
   assign cpu_in_range = CPU_ADDR < MEM_LIM;

   // LD_WE is only good in LOAD and in range; anything else is dropped and flagged.
   assign ld_acc   = LD_WE && (state == ST_LOAD) && ld_in_range;
   assign ld_bad   = LD_WE && !((state == ST_LOAD) && ld_in_range);

   assign CPU_GNT  = (state == ST_RUN) && CPU_REQ;
   assign rd_issue = CPU_GNT && !CPU_WE;
   assign CPU_RST  = (state != ST_RUN);
   assign STATE    = state;

   // Out-of-range reads never touch memory and return zero.
   assign CPU_RVALID = vld_pipe[2];
   assign CPU_RDATA  = vld_pipe[2] ? (oor_pipe[2] ? 32'd0 : MEM_RDATA) : rdata_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= ST_LOAD;
         settle_cnt <= '0;
      end else begin
         state      <= state_nx;
         settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 32'd1 : '0;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_LOAD:   if (LD_DONE) state_nx = ST_SETTLE;
         ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_nx = ST_RUN;
         ST_RUN:    state_nx = ST_RUN;
         default:   state_nx = ST_LOAD;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         MEM_EN    <= 1'b0;
         MEM_WE    <= '0;
         MEM_ADDR  <= '0;
         MEM_WDATA <= '0;
         CSUM      <= '0;
         WCOUNT    <= '0;
         ERR       <= 1'b0;
         vld_pipe  <= '0;
         oor_pipe  <= '0;
         rdata_q   <= '0;
      end else begin
         MEM_EN   <= 1'b0;
         MEM_WE   <= '0;
         vld_pipe <= {vld_pipe[1], rd_issue};
         oor_pipe <= {oor_pipe[1], !cpu_in_range};
         // ld_acc and CPU_GNT are state-exclusive, so no priority question here.
         if (ld_acc) begin
            MEM_EN    <= 1'b1;
            MEM_WE    <= 4'hF;
            MEM_ADDR  <= {LD_ADDR[31:2], 2'b00};
            MEM_WDATA <= LD_DATA;
            CSUM      <= CSUM + LD_DATA;
            WCOUNT    <= WCOUNT + 32'd1;
         end else if (CPU_GNT && cpu_in_range) begin
            MEM_EN    <= 1'b1;
            MEM_WE    <= CPU_WE ? CPU_BE : 4'h0;
            MEM_ADDR  <= {CPU_ADDR[31:2], 2'b00};
            MEM_WDATA <= CPU_WDATA;
         end
         if (ld_bad) ERR <= 1'b1;
         if (vld_pipe[2]) rdata_q <= CPU_RDATA;
      end
   end

endmodule

// File: tb/tb_boot_mem_arbiter.sv
module tb_boot_mem_arbiter;

   localparam int MB = 512 * 1024;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] LD_ADDR, LD_DATA;
   logic        LD_WE, LD_DONE;
   logic        CPU_RST;
   logic        CPU_REQ, CPU_WE;
   logic [3:0]  CPU_BE;
   logic [31:0] CPU_ADDR, CPU_WDATA;
   logic        CPU_GNT;
   logic [31:0] CPU_RDATA;
   logic        CPU_RVALID;
   logic        MEM_EN;
   logic [3:0]  MEM_WE;
   logic [31:0] MEM_ADDR, MEM_WDATA;
   logic [31:0] MEM_RDATA = 32'd0;
   logic [1:0]  STATE;
   logic [31:0] CSUM, WCOUNT;
   logic        ERR;

   int n_chk = 0;
   int n_fail = 0;

   boot_mem_arbiter #(.MEM_BYTES(MB), .RST_HOLD(16)) dut (
      .CLK(CLK), .RST(RST),
      .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA), .LD_WE(LD_WE), .LD_DONE(LD_DONE),
      .CPU_RST(CPU_RST), .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_BE(CPU_BE),
      .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA), .CPU_GNT(CPU_GNT),
      .CPU_RDATA(CPU_RDATA), .CPU_RVALID(CPU_RVALID),
      .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
      .MEM_RDATA(MEM_RDATA), .STATE(STATE), .CSUM(CSUM), .WCOUNT(WCOUNT), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   // Synchronous RAM environment driven purely by the DUT's memory port.
   logic [31:0] env_mem [int];
   int          env_idx;
   logic [31:0] env_w;
   always @(posedge CLK) begin
      if (MEM_EN) begin
         env_idx = int'(MEM_ADDR[31:2]);
         env_w   = env_mem.exists(env_idx) ? env_mem[env_idx] : 32'd0;
         if (MEM_WE == 4'h0) MEM_RDATA <= env_w;
         else begin
            for (int b = 0; b < 4; b++) if (MEM_WE[b]) env_w[8*b +: 8] = MEM_WDATA[8*b +: 8];
            env_mem[env_idx] = env_w;
         end
      end
   end

   // Reference model: what the memory should contain per the boot/CPU rules.
   logic [31:0] ref_mem [int];
   logic [31:0] exp_csum, exp_wc, exp_last_rd;

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      int w;
      w = int'(a[31:2]);
      return ref_mem.exists(w) ? ref_mem[w] : 32'd0;
   endfunction

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs;
      LD_WE = 0; LD_ADDR = 0; LD_DATA = 0;
      CPU_REQ = 0; CPU_WE = 0; CPU_BE = 0; CPU_ADDR = 0; CPU_WDATA = 0;
   endtask

   task automatic test_reset;
      RST = 1; LD_DONE = 0; idle_inputs();
      tick(); tick();
      n_chk++; if (STATE !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", STATE); end
      n_chk++; if (CPU_RST !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_rst: got %b want 1", CPU_RST); end
      n_chk++; if ({CSUM, WCOUNT, ERR} !== 65'd0) begin n_fail++; $display("FAIL reset_counters: csum %h wc %0d err %b want 0", CSUM, WCOUNT, ERR); end
      n_chk++; if ({CPU_GNT, CPU_RVALID, MEM_EN, MEM_WE} !== 7'd0) begin n_fail++; $display("FAIL reset_strobes: got %b want 0", {CPU_GNT, CPU_RVALID, MEM_EN, MEM_WE}); end
      n_chk++; if ({CPU_RDATA, MEM_ADDR, MEM_WDATA} !== 96'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {CPU_RDATA, MEM_ADDR, MEM_WDATA}); end
      RST = 0;
      exp_csum = 0; exp_wc = 0;
   endtask

   task automatic test_cpu_req_in_load;
      CPU_REQ = 1; CPU_WE = 0; CPU_ADDR = 32'h8;
      #1;
      n_chk++; if (CPU_GNT !== 1'b0) begin n_fail++; $display("FAIL load_gnt: got %b want 0", CPU_GNT); end
      tick();
      CPU_REQ = 0;
      n_chk++; if (MEM_EN !== 1'b0) begin n_fail++; $display("FAIL load_cpu_mem_en: got %b want 0", MEM_EN); end
   endtask

   task automatic test_load_directed;
      logic [31:0] d;
      for (int i = 0; i < 4; i++) begin
         d = 32'h11111111 * 32'(i + 1);
         LD_WE = 1; LD_ADDR = 32'(4 * i); LD_DATA = d;
         tick();
         LD_WE = 0;
         ref_mem[i] = d; exp_csum += d; exp_wc++;
         n_chk++; if ({MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA} !== {1'b1, 4'hF, 32'(4 * i), d}) begin
            n_fail++; $display("FAIL load_write%0d: got en %b we %h a %h d %h want 1 f %h %h", i, MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, 32'(4 * i), d);
         end
      end
      n_chk++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL load_err_clean: got %b want 0", ERR); end
      LD_WE = 1; LD_ADDR = 32'(MB); LD_DATA = $urandom;
      tick();
      LD_WE = 0;
      n_chk++; if (MEM_EN !== 1'b0) begin n_fail++; $display("FAIL oor_mem_en: got %b want 0", MEM_EN); end
      n_chk++; if (ERR !== 1'b1) begin n_fail++; $display("FAIL oor_err: got %b want 1", ERR); end
      n_chk++; if ({CSUM, WCOUNT} !== {exp_csum, exp_wc}) begin n_fail++; $display("FAIL oor_csum: got %h/%0d want %h/%0d", CSUM, WCOUNT, exp_csum, exp_wc); end
      LD_DONE = 1;
      tick();
      n_chk++; if (STATE !== 2'd1) begin n_fail++; $display("FAIL settle_entry: got %0d want 1", STATE); end
      n_chk++; if ({CSUM, WCOUNT} !== {32'hAAAAAAAA, 32'd4}) begin n_fail++; $display("FAIL image_sum: got %h/%0d want aaaaaaaa/4", CSUM, WCOUNT); end
   endtask

   // Called right after the edge that entered SETTLE.
   task automatic test_settle;
      int  cyc;
      logic any_en;
      cyc = 0; any_en = 0;
      LD_WE = 1; LD_ADDR = 32'h10; LD_DATA = 32'h5;
      while (CPU_RST === 1'b1 && cyc < 100) begin
         tick();
         LD_WE = 0;
         cyc++;
         if (MEM_EN) any_en = 1;
      end
      n_chk++; if (cyc !== 16) begin n_fail++; $display("FAIL settle_len: got %0d want 16", cyc); end
      n_chk++; if (STATE !== 2'd2) begin n_fail++; $display("FAIL run_state: got %0d want 2", STATE); end
      n_chk++; if (any_en !== 1'b0) begin n_fail++; $display("FAIL settle_ldwe_mem: got %b want 0", any_en); end
   endtask

   task automatic test_read;
      logic [31:0] a [3];
      logic [31:0] e;
      a[0] = 32'h0; a[1] = 32'h4; a[2] = 32'hC;
      CPU_REQ = 1; CPU_WE = 0; CPU_ADDR = 32'h8;
      #1;
      n_chk++; if (CPU_GNT !== 1'b1) begin n_fail++; $display("FAIL run_gnt: got %b want 1", CPU_GNT); end
      tick();
      CPU_REQ = 0;
      n_chk++; if ({MEM_EN, MEM_WE, MEM_ADDR, CPU_RVALID} !== {1'b1, 4'h0, 32'h8, 1'b0}) begin
         n_fail++; $display("FAIL read_issue: got en %b we %h a %h rv %b want 1 0 8 0", MEM_EN, MEM_WE, MEM_ADDR, CPU_RVALID);
      end
      tick();
      n_chk++; if ({CPU_RVALID, CPU_RDATA} !== {1'b1, 32'h33333333}) begin n_fail++; $display("FAIL read_ret: got %b %h want 1 33333333", CPU_RVALID, CPU_RDATA); end
      tick();
      n_chk++; if ({CPU_RVALID, CPU_RDATA} !== {1'b0, 32'h33333333}) begin n_fail++; $display("FAIL read_hold: got %b %h want 0 33333333", CPU_RVALID, CPU_RDATA); end
      for (int k = 0; k < 5; k++) begin
         if (k < 3) begin CPU_REQ = 1; CPU_ADDR = a[k]; end
         else CPU_REQ = 0;
         tick();
         if (k >= 1 && k <= 3) begin
            e = ref_rd(a[k-1]);
            n_chk++; if ({CPU_RVALID, CPU_RDATA} !== {1'b1, e}) begin n_fail++; $display("FAIL b2b_read%0d: got %b %h want 1 %h", k, CPU_RVALID, CPU_RDATA, e); end
         end else begin
            n_chk++; if (CPU_RVALID !== 1'b0) begin n_fail++; $display("FAIL b2b_idle%0d: got %b want 0", k, CPU_RVALID); end
         end
      end
      exp_last_rd = ref_rd(a[2]);
   endtask

   task automatic test_write;
      CPU_REQ = 1; CPU_WE = 1; CPU_BE = 4'b0011; CPU_ADDR = 32'h4; CPU_WDATA = 32'hDEADBEEF;
      tick();
      CPU_REQ = 0; CPU_WE = 0;
      ref_mem[1] = {ref_mem[1][31:16], 16'hBEEF};
      n_chk++; if ({MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA} !== {1'b1, 4'b0011, 32'h4, 32'hDEADBEEF}) begin
         n_fail++; $display("FAIL cpu_write: got en %b we %b a %h d %h want 1 0011 4 deadbeef", MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA);
      end
      tick();
      n_chk++; if (MEM_EN !== 1'b0) begin n_fail++; $display("FAIL cpu_write_len: got %b want 0", MEM_EN); end
   endtask

   task automatic test_run_ldwe;
      LD_WE = 1; LD_ADDR = 32'h0; LD_DATA = 32'h12345678;
      tick();
      LD_WE = 0;
      n_chk++; if ({MEM_EN, ERR} !== 2'b01) begin n_fail++; $display("FAIL run_ldwe: got en %b err %b want 0 1", MEM_EN, ERR); end
      n_chk++; if ({CSUM, WCOUNT} !== {exp_csum, exp_wc}) begin n_fail++; $display("FAIL run_ldwe_csum: got %h/%0d want %h/%0d", CSUM, WCOUNT, exp_csum, exp_wc); end
   endtask

   task automatic test_random_cpu;
      localparam int N = 60;
      logic        xv [0:N+3];
      logic [31:0] xd [0:N+3];
      logic        xen [0:N+3];
      logic [3:0]  xwe [0:N+3];
      logic [31:0] xa [0:N+3];
      logic        req, we, inr;
      logic [3:0]  be;
      logic [31:0] ad, wd, old;
      for (int i = 0; i <= N + 3; i++) begin xv[i] = 0; xd[i] = 0; xen[i] = 0; xwe[i] = 0; xa[i] = 0; end
      for (int i = 0; i < N + 3; i++) begin
         req = (i < N) && ($urandom_range(0, 9) < 7);
         we  = $urandom_range(0, 1) == 1;
         be  = 4'($urandom);
         wd  = $urandom;
         inr = $urandom_range(0, 9) != 0;
         ad  = inr ? 32'($urandom_range(0, 15) * 4) : 32'(MB) + 32'($urandom_range(0, 1023) * 4);
         CPU_REQ = req; CPU_WE = we; CPU_BE = be; CPU_ADDR = ad; CPU_WDATA = wd;
         if (req) begin
            xen[i+1] = inr; xwe[i+1] = we ? be : 4'h0; xa[i+1] = ad;
            if (!we) begin xv[i+2] = 1; xd[i+2] = inr ? ref_rd(ad) : 32'd0; end
            else if (inr) begin
               old = ref_rd(ad);
               for (int b = 0; b < 4; b++) if (be[b]) old[8*b +: 8] = wd[8*b +: 8];
               ref_mem[int'(ad[31:2])] = old;
            end
         end
         #1;
         n_chk++; if (CPU_GNT !== req) begin n_fail++; $display("FAIL rnd_gnt%0d: got %b want %b", i, CPU_GNT, req); end
         tick();
         n_chk++; if (MEM_EN !== xen[i+1] || (xen[i+1] && (MEM_WE !== xwe[i+1] || MEM_ADDR !== xa[i+1]))) begin
            n_fail++; $display("FAIL rnd_mem%0d: got en %b we %h a %h want %b %h %h", i, MEM_EN, MEM_WE, MEM_ADDR, xen[i+1], xwe[i+1], xa[i+1]);
         end
         if (xv[i+1]) exp_last_rd = xd[i+1];
         n_chk++; if ({CPU_RVALID, CPU_RDATA} !== {xv[i+1], exp_last_rd}) begin
            n_fail++; $display("FAIL rnd_rd%0d: got %b %h want %b %h", i, CPU_RVALID, CPU_RDATA, xv[i+1], exp_last_rd);
         end
      end
      idle_inputs();
   endtask

   task automatic test_rst_in_run;
      RST = 1;
      tick();
      RST = 0; LD_DONE = 0;
      n_chk++; if ({STATE, CPU_RST} !== {2'd0, 1'b1}) begin n_fail++; $display("FAIL rst_run_state: got %0d %b want 0 1", STATE, CPU_RST); end
      n_chk++; if ({CSUM, WCOUNT, ERR} !== 65'd0) begin n_fail++; $display("FAIL rst_run_counters: got %h %0d %b want 0", CSUM, WCOUNT, ERR); end
      exp_csum = 0; exp_wc = 0;
   endtask

   task automatic test_random_load;
      int n, cyc;
      logic [31:0] a, d;
      n = $urandom_range(5, 12);
      for (int i = 0; i < n; i++) begin
         a = (i == 0) ? 32'(MB - 4) : 32'($urandom_range(0, MB / 4 - 1) * 4) | 32'($urandom_range(0, 3));
         d = $urandom;
         LD_WE = 1; LD_ADDR = a; LD_DATA = d;
         LD_DONE = (i == n - 1);
         tick();
         LD_WE = 0;
         exp_csum += d; exp_wc++;
         n_chk++; if ({MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA} !== {1'b1, 4'hF, a[31:2], 2'b00, d}) begin
            n_fail++; $display("FAIL rl_write%0d: got en %b we %h a %h d %h want 1 f %h %h", i, MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, {a[31:2], 2'b00}, d);
         end
      end
      n_chk++; if ({STATE, CSUM, WCOUNT, ERR} !== {2'd1, exp_csum, exp_wc, 1'b0}) begin
         n_fail++; $display("FAIL rl_summary: got st %0d %h/%0d err %b want 1 %h/%0d 0", STATE, CSUM, WCOUNT, ERR, exp_csum, exp_wc);
      end
      cyc = 0;
      while (STATE !== 2'd2 && cyc < 100) begin tick(); cyc++; end
      n_chk++; if ({STATE, ERR} !== {2'd2, 1'b0}) begin n_fail++; $display("FAIL rl_run: got st %0d err %b after %0d want 2 0", STATE, ERR, cyc); end
      test_run_ldwe();
   endtask

   initial begin
      test_reset();
      test_cpu_req_in_load();
      test_load_directed();
      test_settle();
      test_read();
      test_write();
      test_run_ldwe();
      test_random_cpu();
      test_rst_in_run();
      test_random_load();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
